// File: rtl/char_sequencer.sv
// Per-frame character controller: button sampling, idle/walk/attack FSM and x position.
// Every register advances only on frame_tick, so outputs hold steady for a whole frame.
module char_sequencer #(
  parameter int START_FRAMES        = 5,
  parameter int ACTIVE_FRAMES       = 2,
  parameter int RECOVERY_FRAMES     = 16,
  parameter int DIR_START_FRAMES    = 4,
  parameter int DIR_ACTIVE_FRAMES   = 3,
  parameter int DIR_RECOVERY_FRAMES = 15,
  parameter int STEP_FWD            = 3,
  parameter int STEP_BACK           = 2,
  parameter int X_MIN               = 0,
  parameter int X_MAX               = 512,
  parameter int X_INIT              = 64,
  parameter int Y_POS               = 240
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_attack,
  output logic [3:0] char_state,
  output logic [9:0] char_x_pos,
  output logic [9:0] char_y_pos,
  output logic       hit_live,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE         = 4'd0,
    LEFT         = 4'd1,
    RIGHT        = 4'd2,
    ATK_START    = 4'd3,
    ATK_ACTIVE   = 4'd4,
    ATK_RECOVERY = 4'd5,
    DIR_START    = 4'd6,
    DIR_ACTIVE   = 4'd7,
    DIR_RECOVERY = 4'd8
  } state_t;

  localparam logic [4:0] L_START     = 5'(START_FRAMES - 1);
  localparam logic [4:0] L_ACTIVE    = 5'(ACTIVE_FRAMES - 1);
  localparam logic [4:0] L_RECOVERY  = 5'(RECOVERY_FRAMES - 1);
  localparam logic [4:0] L_DSTART    = 5'(DIR_START_FRAMES - 1);
  localparam logic [4:0] L_DACTIVE   = 5'(DIR_ACTIVE_FRAMES - 1);
  localparam logic [4:0] L_DRECOVERY = 5'(DIR_RECOVERY_FRAMES - 1);

  state_t      state, state_nxt;
  logic [4:0]  cnt, cnt_nxt;
  logic [9:0]  x, x_nxt;
  logic        atk_prev;
  logic        atk_edge, one_dir;
  logic [10:0] x_ext;
  logic [9:0]  x_left, x_right;

  assign atk_edge = btn_attack & ~atk_prev;
  assign one_dir  = btn_left ^ btn_right;
  assign x_ext    = {1'b0, x};

  // 11-bit compare keeps the clamp free of wrap-around at both edges
  always_comb begin
    x_left  = 10'(x_ext - 11'(STEP_BACK));
    x_right = 10'(x_ext + 11'(STEP_FWD));
    if (x_ext < 11'(X_MIN + STEP_BACK))        x_left  = 10'(X_MIN);
    if (x_ext + 11'(STEP_FWD) > 11'(X_MAX))    x_right = 10'(X_MAX);
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    x_nxt     = x;
    case (state)
      IDLE, LEFT, RIGHT: begin
        if (atk_edge && one_dir) begin
          state_nxt = DIR_START;
          cnt_nxt   = L_DSTART;
        end else if (atk_edge) begin
          state_nxt = ATK_START;
          cnt_nxt   = L_START;
        end else if (btn_left && !btn_right) begin
          state_nxt = LEFT;
          x_nxt     = x_left;
        end else if (btn_right && !btn_left) begin
          state_nxt = RIGHT;
          x_nxt     = x_right;
        end else begin
          state_nxt = IDLE;
        end
      end
      ATK_START: begin
        if (cnt != 5'd0) cnt_nxt = cnt - 5'd1;
        else begin state_nxt = ATK_ACTIVE; cnt_nxt = L_ACTIVE; end
      end
      ATK_ACTIVE: begin
        if (cnt != 5'd0) cnt_nxt = cnt - 5'd1;
        else begin state_nxt = ATK_RECOVERY; cnt_nxt = L_RECOVERY; end
      end
      ATK_RECOVERY: begin
        if (cnt != 5'd0) cnt_nxt = cnt - 5'd1;
        else begin state_nxt = IDLE; cnt_nxt = 5'd0; end
      end
      DIR_START: begin
        if (cnt != 5'd0) cnt_nxt = cnt - 5'd1;
        else begin state_nxt = DIR_ACTIVE; cnt_nxt = L_DACTIVE; end
      end
      DIR_ACTIVE: begin
        if (cnt != 5'd0) cnt_nxt = cnt - 5'd1;
        else begin state_nxt = DIR_RECOVERY; cnt_nxt = L_DRECOVERY; end
      end
      DIR_RECOVERY: begin
        if (cnt != 5'd0) cnt_nxt = cnt - 5'd1;
        else begin state_nxt = IDLE; cnt_nxt = 5'd0; end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 5'd0;
      end
    endcase
  end

  // atk_prev resets high so a button held through reset cannot fire
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 5'd0;
      x        <= 10'(X_INIT);
      atk_prev <= 1'b1;
      hit_live <= 1'b0;
      busy     <= 1'b0;
    end else if (frame_tick) begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      x        <= x_nxt;
      atk_prev <= btn_attack;
      hit_live <= (state_nxt == ATK_ACTIVE) || (state_nxt == DIR_ACTIVE);
      busy     <= state_nxt inside {ATK_START, ATK_ACTIVE, ATK_RECOVERY,
                                    DIR_START, DIR_ACTIVE, DIR_RECOVERY};
    end
  end

  assign char_state = state;
  assign char_x_pos = x;
  assign char_y_pos = 10'(Y_POS);

endmodule

// File: tb/tb_char_sequencer.sv
// Bench for char_sequencer: directed scenarios plus random buttons, checked against
// a queue-based model of the attack schedule and plain-integer position arithmetic.
module tb_char_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_attack = 1'b0;
  logic [3:0] char_state;
  logic [9:0] char_x_pos, char_y_pos;
  logic       hit_live, busy;

  int n_chk = 0, n_fail = 0;

  // model: current state, x, previous attack level, queued future attack states
  int m_st, m_x;
  bit m_prev;
  int m_q[$];

  char_sequencer dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .btn_left(btn_left), .btn_right(btn_right), .btn_attack(btn_attack),
    .char_state(char_state), .char_x_pos(char_x_pos), .char_y_pos(char_y_pos),
    .hit_live(hit_live), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_x = 64; m_prev = 1'b1; m_q.delete();
  endtask

  task automatic push_seq(input int s, input int ns, input int a, input int na,
                          input int r, input int nr);
    for (int i = 0; i < ns; i++) m_q.push_back(s);
    for (int i = 0; i < na; i++) m_q.push_back(a);
    for (int i = 0; i < nr; i++) m_q.push_back(r);
    m_q.push_back(0);
  endtask

  task automatic model_step(input bit l, input bit r, input bit a);
    bit edge_seen;
    edge_seen = a && !m_prev;
    m_prev = a;
    if (m_q.size() > 0) m_st = m_q.pop_front();
    else if (edge_seen) begin
      if (l ^ r) push_seq(6, 4, 7, 3, 8, 15);
      else       push_seq(3, 5, 4, 2, 5, 16);
      m_st = m_q.pop_front();
    end else if (l && !r) begin
      m_st = 1; m_x = (m_x - 2 < 0) ? 0 : m_x - 2;
    end else if (r && !l) begin
      m_st = 2; m_x = (m_x + 3 > 512) ? 512 : m_x + 3;
    end else m_st = 0;
  endtask

  task automatic check_out(input string tag);
    chk({tag, ".state"}, 32'(char_state), 32'(m_st));
    chk({tag, ".x"}, 32'(char_x_pos), 32'(m_x));
    chk({tag, ".y"}, 32'(char_y_pos), 32'd240);
    chk({tag, ".hit"}, 32'(hit_live), 32'(m_st == 4 || m_st == 7));
    chk({tag, ".busy"}, 32'(busy), 32'(m_st >= 3 && m_st <= 8));
  endtask

  task automatic do_tick(input bit l, input bit r, input bit a);
    btn_left = l; btn_right = r; btn_attack = a; frame_tick = 1'b1;
    @(posedge clk);
    model_step(l, r, a);
    #1 frame_tick = 1'b0;
    check_out("tick");
  endtask

  // cycles without a tick: buttons wiggle, nothing may change
  task automatic quiet_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b0;
      btn_left = 1'($urandom); btn_right = 1'($urandom); btn_attack = 1'($urandom);
      @(posedge clk);
      #1 check_out("quiet");
    end
  endtask

  initial begin
    model_reset();
    btn_attack = 1'b1;
    #12 check_out("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // attack held through reset must not fire
    for (int i = 0; i < 3; i++) begin
      do_tick(0, 0, 1);
      chk("held_atk_state", 32'(char_state), 32'd0);
    end
    do_tick(0, 0, 0);

    for (int i = 0; i < 3; i++) begin
      do_tick(0, 1, 0);
      chk("right_x", 32'(char_x_pos), 32'(67 + 3 * i));
      chk("right_state", 32'(char_state), 32'd2);
    end
    do_tick(1, 1, 0);
    chk("both_state", 32'(char_state), 32'd0);
    chk("both_x", 32'(char_x_pos), 32'd73);

    // walk to exactly 510, then clamp at 512
    while (m_x < 508) do_tick(0, 1, 0);
    do_tick(1, 0, 0); do_tick(1, 0, 0);
    do_tick(0, 1, 0); do_tick(0, 1, 0);
    chk("x_510", 32'(char_x_pos), 32'd510);
    do_tick(0, 1, 0); chk("clamp_hi_1", 32'(char_x_pos), 32'd512);
    do_tick(0, 1, 0); chk("clamp_hi_2", 32'(char_x_pos), 32'd512);

    // reach x=1, then clamp at 0
    for (int i = 0; i < 300 && m_x > 0; i++) do_tick(1, 0, 0);
    do_tick(0, 1, 0); do_tick(1, 0, 0);
    chk("x_1", 32'(char_x_pos), 32'd1);
    do_tick(1, 0, 0); chk("clamp_lo", 32'(char_x_pos), 32'd0);
    do_tick(0, 1, 0); do_tick(0, 1, 0);

    // neutral attack at k=0, left held afterwards
    begin
      int x0, es;
      x0 = m_x;
      do_tick(0, 0, 0);
      for (int k = 0; k <= 24; k++) begin
        if (k == 0) do_tick(0, 0, 1); else do_tick(1, 0, 0);
        es = (k < 5) ? 3 : (k < 7) ? 4 : (k < 23) ? 5 : (k == 23) ? 0 : 1;
        chk("atk_seq", 32'(char_state), 32'(es));
        chk("atk_x", 32'(char_x_pos), 32'((k < 24) ? x0 : x0 - 2));
      end
    end

    // directional attack with left held
    begin
      int x0, es;
      do_tick(0, 0, 0);
      x0 = m_x;
      for (int k = 0; k <= 22; k++) begin
        do_tick(1, 0, k == 0);
        es = (k < 4) ? 6 : (k < 7) ? 7 : (k < 22) ? 8 : 0;
        chk("dir_seq", 32'(char_state), 32'(es));
        if (k < 22) chk("dir_x", 32'(char_x_pos), 32'(x0));
      end
    end

    // asynchronous reset in DIR_ACTIVE
    do_tick(0, 0, 0);
    for (int k = 0; k < 5; k++) do_tick(0, 1, k == 0);
    chk("pre_rst_state", 32'(char_state), 32'd7);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_out("async_rst");
    @(posedge clk); #1 rst_n = 1'b1;
    do_tick(0, 0, 0);
    chk("post_rst_state", 32'(char_state), 32'd0);

    // random traffic: back-to-back ticks and gaps, attack pressed sparingly
    for (int i = 0; i < 2000; i++) begin
      do_tick(1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 3) == 0) quiet_cycles($urandom_range(1, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
